// File: rtl/imem_resp_if.sv
// Fetch-side bus of the instruction-memory responder: fetch request and
// redirect, the memory load port, and the returned instruction/status.
interface imem_resp_if #(
  parameter int AW = 10
);
  logic [31:0]   pcfetch;
  logic          req;
  logic          flush;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic [31:0]   instr;
  logic          instr_valid;
  logic          busy;
  logic          fault;

  // Fetch stage / boot loader side.
  modport master (
    output pcfetch, req, flush, ld_en, ld_addr, ld_data,
    input  instr, instr_valid, busy, fault
  );

  // Instruction-memory side.
  modport slave (
    input  pcfetch, req, flush, ld_en, ld_addr, ld_data,
    output instr, instr_valid, busy, fault
  );
endinterface

// File: rtl/imem_resp.sv
// Instruction-memory responder for the fetch stage. Accepts a fetch address,
// waits LATENCY edges, then returns one instruction with a one-cycle valid
// pulse. Misaligned or out-of-range fetches set a sticky fault and return 0.
// LATENCY must be at least 1.
module imem_resp #(
  parameter logic [31:0] BASE    = 32'h0010_0000,
  parameter int          DEPTH   = 1024,
  parameter int          AW      = $clog2(DEPTH),
  parameter int          LATENCY = 2
) (
  input logic          clk,
  input logic          rst,
  imem_resp_if.slave   bus
);

  localparam int             CW        = $clog2(LATENCY) + 1;
  localparam logic [CW-1:0]  CNT_INIT  = CW'(LATENCY - 1);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
  localparam logic [31:0]    MEM_BYTES = 32'(DEPTH * 4);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  logic [31:0] mem [DEPTH];

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   instr_q, instr_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          fault_q, fault_d;

  logic [31:0]   off;
  logic          addr_ok;

  // Byte offset from the memory base; wraps so addresses below BASE fail the range test.
  assign off     = bus.pcfetch - BASE;
  assign addr_ok = (bus.pcfetch[1:0] == 2'b00) && (off < MEM_BYTES);

  // Load port: write-only, any state. The fetch read sees pre-edge contents,
  // so a load on the completion edge to the same word returns the old data.
  // NOTE: memory contents are deliberately not reset; an array reset would
  // stop it mapping onto a RAM macro and software always loads before fetching.
  always_ff @(posedge clk) begin
    if (bus.ld_en) begin
      mem[bus.ld_addr] <= bus.ld_data;
    end
  end

  // Next-state and registered-output logic for the IDLE/WAIT controller.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    instr_d = instr_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    fault_d = fault_q;

    case (state_q)
      IDLE: begin
        if (!bus.flush && bus.req) begin
          if (addr_ok) begin
            idx_d   = off[AW+1:2];
            cnt_d   = CNT_INIT;
            busy_d  = 1'b1;
            state_d = WAIT;
          end else begin
            fault_d = 1'b1;
            instr_d = 32'h0;
            valid_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (bus.flush) begin
          // Redirect discards the fetch even on its completion edge.
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          instr_d = mem[idx_q];
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset has priority over every input.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
    end
  end

  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.busy        = busy_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_imem_resp.sv
// Directed bench for imem_resp (BASE 0x00100000, DEPTH 1024, LATENCY 2).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_imem_resp;

  localparam logic [31:0] BASE = 32'h0010_0000;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  imem_resp_if #(.AW(10)) bus ();

  imem_resp #(
    .BASE    (BASE),
    .DEPTH   (1024),
    .AW      (10),
    .LATENCY (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle so outputs reflect that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] e_instr,
                           input logic e_valid, input logic e_busy, input logic e_fault);
    check({tag, ".instr"}, bus.instr, e_instr);
    check({tag, ".valid"}, 32'(bus.instr_valid), 32'(e_valid));
    check({tag, ".busy"},  32'(bus.busy),        32'(e_busy));
    check({tag, ".fault"}, 32'(bus.fault),       32'(e_fault));
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    bus.ld_en   = 1'b1;
    bus.ld_addr = a;
    bus.ld_data = d;
    tick();
    bus.ld_en   = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    bus.pcfetch = 32'h0;
    bus.req     = 1'b0;
    bus.flush   = 1'b0;
    bus.ld_en   = 1'b0;
    bus.ld_addr = '0;
    bus.ld_data = 32'h0;

    // Reset state
    tick();
    tick();
    check_out("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    load(10'd0,    32'h2008_0005);
    load(10'd1,    32'h8C09_0000);
    load(10'd1023, 32'h1234_5678);

    // 1. Basic fetch: busy two cycles, then one valid pulse
    bus.req = 1'b1; bus.pcfetch = BASE;
    tick();                                   // E0
    bus.req = 1'b0;
    check_out("basic.e0", 32'h0, 1'b0, 1'b1, 1'b0);
    tick();                                   // E1
    check_out("basic.e1", 32'h0, 1'b0, 1'b1, 1'b0);
    tick();                                   // E2
    check_out("basic.e2", 32'h2008_0005, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("basic.hold", 32'h2008_0005, 1'b0, 1'b0, 1'b0);

    // 2. Back-to-back with req held: pulses at E2 and E5
    bus.req = 1'b1; bus.pcfetch = BASE;
    tick();                                   // E0
    check_out("b2b.e0", 32'h2008_0005, 1'b0, 1'b1, 1'b0);
    tick();                                   // E1 (req ignored in WAIT)
    check_out("b2b.e1", 32'h2008_0005, 1'b0, 1'b1, 1'b0);
    tick();                                   // E2
    check_out("b2b.e2", 32'h2008_0005, 1'b1, 1'b0, 1'b0);
    bus.pcfetch = BASE + 32'd4;
    tick();                                   // E3 accept
    bus.req = 1'b0;
    check_out("b2b.e3", 32'h2008_0005, 1'b0, 1'b1, 1'b0);
    tick();                                   // E4
    check_out("b2b.e4", 32'h2008_0005, 1'b0, 1'b1, 1'b0);
    tick();                                   // E5
    check_out("b2b.e5", 32'h8C09_0000, 1'b1, 1'b0, 1'b0);

    // 3. Flush at E1 discards the fetch; flush in IDLE masks req
    bus.req = 1'b1; bus.pcfetch = BASE;
    tick();                                   // E0
    bus.req = 1'b0; bus.flush = 1'b1;
    tick();                                   // E1 flush
    bus.flush = 1'b0;
    check_out("flush.e1", 32'h8C09_0000, 1'b0, 1'b0, 1'b0);
    tick();
    check_out("flush.e2", 32'h8C09_0000, 1'b0, 1'b0, 1'b0);
    bus.req = 1'b1; bus.flush = 1'b1;
    tick();
    bus.req = 1'b0; bus.flush = 1'b0;
    check_out("flush.idle", 32'h8C09_0000, 1'b0, 1'b0, 1'b0);
    tick();
    check_out("flush.idle2", 32'h8C09_0000, 1'b0, 1'b0, 1'b0);
    bus.req = 1'b1; bus.pcfetch = BASE;
    tick();
    bus.req = 1'b0;
    tick();
    tick();
    check_out("flush.refetch", 32'h2008_0005, 1'b1, 1'b0, 1'b0);

    // 4. Faults: misaligned, then one past the end
    bus.req = 1'b1; bus.pcfetch = 32'h0010_0002;
    tick();
    check_out("fault.misalign", 32'h0, 1'b1, 1'b0, 1'b1);
    bus.pcfetch = 32'h0010_1000;
    tick();
    check_out("fault.range", 32'h0, 1'b1, 1'b0, 1'b1);
    bus.pcfetch = 32'h000F_FFFC;
    tick();
    check_out("fault.below", 32'h0, 1'b1, 1'b0, 1'b1);
    bus.pcfetch = BASE + 32'd4;
    tick();                                   // good fetch E0
    bus.req = 1'b0;
    check_out("fault.good.e0", 32'h0, 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    check_out("fault.sticky", 32'h8C09_0000, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_out("fault.rst", 32'h0, 1'b0, 1'b0, 1'b0);

    // Last word in range is a good address
    bus.req = 1'b1; bus.pcfetch = 32'h0010_0FFC;
    tick();
    bus.req = 1'b0;
    check_out("last.e0", 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    check_out("last.e2", 32'h1234_5678, 1'b1, 1'b0, 1'b0);

    // 5. Reset mid-fetch: no pulse afterwards
    bus.req = 1'b1; bus.pcfetch = BASE + 32'd4;
    tick();                                   // E0
    bus.req = 1'b0; rst = 1'b1;
    tick();                                   // E1 reset
    rst = 1'b0;
    check_out("rstmid.e1", 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("rstmid.after", 32'h0, 1'b0, 1'b0, 1'b0);
    end
    bus.req = 1'b1; bus.pcfetch = BASE;
    tick();
    bus.req = 1'b0;
    tick();
    tick();
    check_out("rstmid.refetch", 32'h2008_0005, 1'b1, 1'b0, 1'b0);

    // 6. Load collision on the completion edge returns old data
    bus.req = 1'b1; bus.pcfetch = BASE;
    tick();                                   // E0
    bus.req = 1'b0;
    tick();                                   // E1
    bus.ld_en = 1'b1; bus.ld_addr = 10'd0; bus.ld_data = 32'hDEAD_BEEF;
    tick();                                   // E2 completion + load
    bus.ld_en = 1'b0;
    check_out("coll.old", 32'h2008_0005, 1'b1, 1'b0, 1'b0);
    bus.req = 1'b1; bus.pcfetch = BASE;
    tick();
    bus.req = 1'b0;
    tick();
    tick();
    check_out("coll.new", 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_resp.md
# imem_resp

Instruction-memory responder for the fetch stage. It accepts a fetch address from the PC fetch register, waits a fixed read latency, and returns one 32-bit instruction with a single-cycle valid pulse. While a fetch is outstanding it drives `busy`, which the hazard unit ORs into `stallf`. Misaligned and out-of-range fetches raise a sticky fault and return a NOP.

## Interface
- `BASE`, 32'h0010_0000: byte address of instruction word 0.
- `DEPTH`, 1024: memory size in 32-bit words.
- `AW`, 10: word-address width, clog2(DEPTH).
- `LATENCY`, 2: number of clock edges from request accept to data; must be ≥ 1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `pcfetch`  in  32  fetch byte address.
- `req`  in  1  fetch request; qualifies `pcfetch`.
- `flush`  in  1  branch redirect; discards the outstanding fetch.
- `ld_en`  in  1  memory load strobe, for the bench or boot loader.
- `ld_addr`  in  AW  load word address.
- `ld_data`  in  32  load data.
- `instr`  out  32  fetched instruction. Holds its value when `instr_valid` is low.
- `instr_valid`  out  1  one-cycle pulse, registered.
- `busy`  out  1  high while a fetch is outstanding, registered.
- `fault`  out  1  sticky bad-address flag.

## Operation
- Address check:
  - `off = pcfetch - BASE`, computed as 32-bit unsigned with wrap.
  - Good if `pcfetch[1:0] == 0` and `off < DEPTH*4`.
  - Word index is `off[AW+1:2]`.
- States are IDLE and WAIT. A down-counter `cnt` has width clog2(LATENCY)+1.
- IDLE:
  - `flush` high: ignore `req`, stay in IDLE.
  - `req` high with a bad address: `fault <= 1`, `instr <= 0`, `instr_valid <= 1`. Stay in IDLE; `busy` stays 0.
  - `req` high with a good address: latch the word index, `cnt <= LATENCY-1`, `busy <= 1`, go to WAIT.
- WAIT:
  - `flush` high: go to IDLE, `busy <= 0`, no `instr_valid`, `instr` unchanged. Flush wins even on the completion edge.
  - Else if `cnt == 0`: `instr <= mem[idx]`, `instr_valid <= 1`, `busy <= 0`, go to IDLE.
  - Else: `cnt <= cnt - 1`.
  - `req` is ignored in WAIT.
- `instr_valid` defaults to 0 on every edge not listed above.
- Load port:
  - On an edge with `ld_en` high, `mem[ld_addr] <= ld_data`. Accepted in any state.
  - Memory is read-before-write. A load on the completion edge to the same word returns the old data.
- `fault` clears only on `rst`.
- Reset values: `instr` = 0, `instr_valid` = 0, `busy` = 0, `fault` = 0, state IDLE, `cnt` = 0. Memory contents are not reset.
- `rst` has priority over all other inputs. `rst` during WAIT aborts the fetch: no valid pulse afterward.

## Timing
- Good fetch:
  - `req` is sampled at edge E0.
  - `busy` is high in the cycles after edges E0 through E(L-1).
  - `instr`/`instr_valid` update at edge E(L), where L = LATENCY. The valid pulse is seen in the cycle after E(L), and `busy` is low in that cycle.
- A new `req` can be accepted at E(L+1). Maximum throughput is one fetch per L+1 cycles.
- Bad fetch: the valid pulse with `instr` = 0 follows edge E0 directly. Latency is 1 and `busy` never asserts.
- LATENCY = 1: `busy` high for exactly one cycle; data at E1.

## Test plan
All scenarios use BASE 0x00100000, DEPTH 1024, LATENCY 2.

1. **Basic fetch.** Reset, load word 0 = 0x20080005, `req` with `pcfetch` 0x00100000 at E0 → `busy` high for 2 cycles, then `instr_valid` = 1 for one cycle with `instr` = 0x20080005.
2. **Back-to-back.** `req` held high; `pcfetch` 0x00100000, then 0x00100004 presented on the accept edge (word 1 = 0x8C090000) → valid pulses 3 cycles apart, returning 0x20080005 then 0x8C090000.
3. **Flush.** `flush` at E1 of an outstanding fetch → no `instr_valid`, `busy` low after E1, `instr` keeps its prior value. Next `req` completes normally.
4. **Fault.** `pcfetch` 0x00100002, then 0x00101000 → each gives `instr_valid` after E0 with `instr` = 0 and `fault` = 1, `busy` = 0. After a later good fetch `fault` is still 1; `rst` clears it.
5. **Reset mid-fetch.** `rst` at E1 while in WAIT → next cycle all outputs 0 and no valid pulse ever follows. A post-reset fetch works.
6. **Load collision.** `ld_en` to word 0 with 0xDEADBEEF on the completion edge of a word-0 fetch → returns the old 0x20080005; the next word-0 fetch returns 0xDEADBEEF.
